// File: rtl/msg_request_scheduler.sv
// Request scheduler for the create-message engine.
// Session-message requests (logon, heartbeat, resendReq, logout) are queued in
// arrival order. One request at a time is handed to the engine. The next request
// is held back until the engine reports done, or until the watchdog gives up.
module msg_request_scheduler #(
  parameter int NUM_HOST = 10,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_i,
  input  logic [3:0]                    req_type_i,
  input  logic [NUM_HOST-1:0]           req_host_i,
  input  logic                          flush_i,
  input  logic                          clr_overflow_i,
  input  logic                          cm_busy_i,
  input  logic                          cm_done_i,
  output logic                          initiate_msg_o,
  output logic [3:0]                    create_message_o,
  output logic [NUM_HOST-1:0]           host_o,
  output logic                          busy_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o,
  output logic                          timeout_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE,
    WAIT_DONE
  } state_t;

  state_t              state, state_d;
  logic [WD_W-1:0]     wd_cnt, wd_cnt_d;
  logic                initiate_d;
  logic                timeout_d;
  logic                pop;
  logic                push;
  logic                type_ok;
  logic                full;
  logic                drop;

  logic [3:0]          type_mem [DEPTH];
  logic [NUM_HOST-1:0] host_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  // Only message types 1..4 are meaningful; anything else is dropped silently.
  assign type_ok = (req_type_i != 4'd0) && (req_type_i <= 4'd4);
  assign full    = (count == FULL_CNT);
  // A flush discards the same-edge request without counting it as an overflow.
  assign push    = req_valid_i && type_ok && !full && !flush_i;
  // Full is judged before any same-edge pop, so a request arriving while full is lost.
  assign drop    = req_valid_i && type_ok && full && !flush_i;

  assign busy_o  = (state != IDLE) || (count != '0);
  assign count_o = count;

  // Queue storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr] <= req_type_i;
      host_mem[wr_ptr] <= req_host_i;
    end
  end

  // Queue pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  // Issue/wait decision and watchdog for the in-flight message.
  always_comb begin
    state_d    = state;
    wd_cnt_d   = wd_cnt;
    pop        = 1'b0;
    initiate_d = 1'b0;
    timeout_d  = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !cm_busy_i && !flush_i) begin
          pop        = 1'b1;
          initiate_d = 1'b1;
          wd_cnt_d   = '0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cm_done_i) begin
          state_d = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          // The engine never answered: abandon this message and move on.
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, watchdog and registered outputs; type/host hold until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wd_cnt           <= '0;
      initiate_msg_o   <= 1'b0;
      timeout_err_o    <= 1'b0;
      create_message_o <= '0;
      host_o           <= '0;
    end else begin
      state          <= state_d;
      wd_cnt         <= wd_cnt_d;
      initiate_msg_o <= initiate_d;
      timeout_err_o  <= timeout_d;
      if (pop) begin
        create_message_o <= type_mem[rd_ptr];
        host_o           <= host_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_msg_request_scheduler.sv
// Directed bench for msg_request_scheduler with hand-computed expectations.
module tb_msg_request_scheduler;

  localparam int NUM_HOST = 10;
  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 255;

  logic                clk;
  logic                rst;
  logic                req_valid_i;
  logic [3:0]          req_type_i;
  logic [NUM_HOST-1:0] req_host_i;
  logic                flush_i;
  logic                clr_overflow_i;
  logic                cm_busy_i;
  logic                cm_done_i;
  logic                initiate_msg_o;
  logic [3:0]          create_message_o;
  logic [NUM_HOST-1:0] host_o;
  logic                busy_o;
  logic [2:0]          count_o;
  logic                overflow_o;
  logic                timeout_err_o;

  int checks = 0;
  int errors = 0;

  msg_request_scheduler #(
    .NUM_HOST (NUM_HOST),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_type_i       (req_type_i),
    .req_host_i       (req_host_i),
    .flush_i          (flush_i),
    .clr_overflow_i   (clr_overflow_i),
    .cm_busy_i        (cm_busy_i),
    .cm_done_i        (cm_done_i),
    .initiate_msg_o   (initiate_msg_o),
    .create_message_o (create_message_o),
    .host_o           (host_o),
    .busy_o           (busy_o),
    .count_o          (count_o),
    .overflow_o       (overflow_o),
    .timeout_err_o    (timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [3:0] t, input logic [NUM_HOST-1:0] h);
    req_valid_i = 1'b1;
    req_type_i  = t;
    req_host_i  = h;
    tick();
    req_valid_i = 1'b0;
    req_type_i  = 4'd0;
    req_host_i  = '0;
  endtask

  task automatic done_pulse();
    cm_done_i = 1'b1;
    tick();
    cm_done_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({initiate_msg_o, create_message_o, host_o, busy_o, count_o, overflow_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got init=%0b type=%0d host=%0d busy=%0b count=%0d ovf=%0b tmo=%0b, want all 0",
               initiate_msg_o, create_message_o, host_o, busy_o, count_o, overflow_o, timeout_err_o);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    push_req(4'd1, 10'd3);
    checks++;
    if (count_o !== 3'd1 || initiate_msg_o !== 1'b0) begin
      errors++;
      $display("FAIL single_queued: got count=%0d init=%0b, want count=1 init=0", count_o, initiate_msg_o);
    end
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd1 || host_o !== 10'd3 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL single_issue: got init=%0b type=%0d host=%0d count=%0d, want 1/1/3/0",
               initiate_msg_o, create_message_o, host_o, count_o);
    end
    tick();
    checks++;
    if (initiate_msg_o !== 1'b0 || create_message_o !== 4'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: got init=%0b type=%0d busy=%0b, want 0/1/1", initiate_msg_o, create_message_o, busy_o);
    end
    done_pulse();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%0b, want 0", busy_o);
    end
  endtask

  task automatic test_busy_hold();
    cm_busy_i = 1'b1;
    push_req(4'd2, 10'd5);
    push_req(4'd3, 10'd7);
    tick();
    tick();
    checks++;
    if (initiate_msg_o !== 1'b0 || count_o !== 3'd2) begin
      errors++;
      $display("FAIL busy_hold: got init=%0b count=%0d, want 0/2", initiate_msg_o, count_o);
    end
    cm_busy_i = 1'b0;
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd2 || host_o !== 10'd5 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL busy_first: got init=%0b type=%0d host=%0d count=%0d, want 1/2/5/1",
               initiate_msg_o, create_message_o, host_o, count_o);
    end
    tick();
    tick();
    checks++;
    if (initiate_msg_o !== 1'b0 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL busy_waits_done: got init=%0b count=%0d, want 0/1", initiate_msg_o, count_o);
    end
    done_pulse();
    checks++;
    if (initiate_msg_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle_gap: got init=%0b, want 0", initiate_msg_o);
    end
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd3 || host_o !== 10'd7 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL busy_second: got init=%0b type=%0d host=%0d count=%0d, want 1/3/7/0",
               initiate_msg_o, create_message_o, host_o, count_o);
    end
    tick();
    done_pulse();
  endtask

  task automatic test_back_to_back();
    cm_busy_i = 1'b1;
    push_req(4'd1, 10'd2);
    push_req(4'd3, 10'd4);
    // Pop and push on the same edge: occupancy must stay at 2.
    cm_busy_i   = 1'b0;
    push_req(4'd4, 10'd6);
    checks++;
    if (count_o !== 3'd2 || initiate_msg_o !== 1'b1 || create_message_o !== 4'd1 || host_o !== 10'd2) begin
      errors++;
      $display("FAIL b2b_push_pop: got count=%0d init=%0b type=%0d host=%0d, want 2/1/1/2",
               count_o, initiate_msg_o, create_message_o, host_o);
    end
    done_pulse();
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd3 || host_o !== 10'd4) begin
      errors++;
      $display("FAIL b2b_second: got init=%0b type=%0d host=%0d, want 1/3/4", initiate_msg_o, create_message_o, host_o);
    end
    done_pulse();
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd4 || host_o !== 10'd6 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL b2b_third: got init=%0b type=%0d host=%0d count=%0d, want 1/4/6/0",
               initiate_msg_o, create_message_o, host_o, count_o);
    end
    done_pulse();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%0b, want 0", busy_o);
    end
  endtask

  task automatic test_overflow();
    cm_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_req(4'((i % 4) + 1), 10'(i + 1));
    end
    checks++;
    if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d ovf=%0b, want 4/1", count_o, overflow_o);
    end
    // New drop and clear on the same edge: the flag must stay set.
    clr_overflow_i = 1'b1;
    push_req(4'd2, 10'd9);
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set_and_clear: got ovf=%0b count=%0d, want 1/4", overflow_o, count_o);
    end
    tick();
    clr_overflow_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%0b, want 0", overflow_o);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flush: got count=%0d ovf=%0b, want 0/0", count_o, overflow_o);
    end
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    cm_busy_i = 1'b0;
    push_req(4'd4, 10'd9);
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd4 || host_o !== 10'd9) begin
      errors++;
      $display("FAIL tmo_issue: got init=%0b type=%0d host=%0d, want 1/4/9", initiate_msg_o, create_message_o, host_o);
    end
    n    = 0;
    seen = 1'b0;
    while (n < 400 && !seen) begin
      tick();
      n++;
      if (timeout_err_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n !== TIMEOUT) begin
      errors++;
      $display("FAIL tmo_pulse: got seen=%0b after %0d cycles, want seen=1 after %0d", seen, n, TIMEOUT);
    end
    tick();
    checks++;
    if (timeout_err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: got tmo=%0b busy=%0b, want 0/0", timeout_err_o, busy_o);
    end
    push_req(4'd2, 10'd1);
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd2 || host_o !== 10'd1) begin
      errors++;
      $display("FAIL tmo_next_issue: got init=%0b type=%0d host=%0d, want 1/2/1", initiate_msg_o, create_message_o, host_o);
    end
    done_pulse();
  endtask

  task automatic test_flush_invalid();
    cm_busy_i = 1'b1;
    push_req(4'd1, 10'd1);
    push_req(4'd2, 10'd2);
    push_req(4'd3, 10'd3);
    checks++;
    if (count_o !== 3'd3) begin
      errors++;
      $display("FAIL flush_queued: got count=%0d, want 3", count_o);
    end
    flush_i = 1'b1;
    push_req(4'd4, 10'd4);
    flush_i = 1'b0;
    checks++;
    if (count_o !== 3'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_with_push: got count=%0d ovf=%0b, want 0/0", count_o, overflow_o);
    end
    push_req(4'd0, 10'd5);
    push_req(4'd7, 10'd6);
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL invalid_types: got count=%0d, want 0", count_o);
    end
    push_req(4'd5, 10'd6);
    push_req(4'd4, 10'd8);
    checks++;
    if (count_o !== 3'd1) begin
      errors++;
      $display("FAIL mixed_types: got count=%0d, want 1", count_o);
    end
    // Only the type-4 entry may come out.
    cm_busy_i = 1'b0;
    tick();
    checks++;
    if (initiate_msg_o !== 1'b1 || create_message_o !== 4'd4 || host_o !== 10'd8) begin
      errors++;
      $display("FAIL mixed_issue: got init=%0b type=%0d host=%0d, want 1/4/8", initiate_msg_o, create_message_o, host_o);
    end
    done_pulse();
  endtask

  task automatic test_reset_mid_wait();
    int issued;
    cm_busy_i = 1'b0;
    push_req(4'd3, 10'd8);
    tick();
    cm_busy_i = 1'b1;
    push_req(4'd1, 10'd1);
    push_req(4'd2, 10'd2);
    checks++;
    if (count_o !== 3'd2 || busy_o !== 1'b1 || create_message_o !== 4'd3) begin
      errors++;
      $display("FAIL rst_pre: got count=%0d busy=%0b type=%0d, want 2/1/3", count_o, busy_o, create_message_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({initiate_msg_o, create_message_o, host_o, busy_o, count_o, overflow_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL rst_async: got init=%0b type=%0d host=%0d busy=%0b count=%0d ovf=%0b tmo=%0b, want all 0",
               initiate_msg_o, create_message_o, host_o, busy_o, count_o, overflow_o, timeout_err_o);
    end
    tick();
    rst       = 1'b0;
    cm_busy_i = 1'b0;
    issued    = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (initiate_msg_o === 1'b1) issued++;
    end
    checks++;
    if (issued !== 0 || count_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_issue: got issues=%0d count=%0d busy=%0b, want 0/0/0", issued, count_o, busy_o);
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_valid_i    = 1'b0;
    req_type_i     = 4'd0;
    req_host_i     = '0;
    flush_i        = 1'b0;
    clr_overflow_i = 1'b0;
    cm_busy_i      = 1'b0;
    cm_done_i      = 1'b0;
    test_reset();
    test_single();
    test_busy_hold();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_flush_invalid();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
